// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 panel driver.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Default timing at 50 MHz: 1.2 us bit, 0.3/0.9 us high, 300 us latch gap.
  localparam int T_BIT_D        = 60;
  localparam int T_H0_D         = 15;
  localparam int T_H1_D         = 45;
  localparam int T_RST_D        = 15000;

  // 8x8 panel, GRB 8:8:8 per pixel.
  localparam int N_PIXEL_D      = 64;
  localparam int BITS_PER_PIXEL = 24;

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter and NRZ encoder: produces the registered dout line
// and a strobe on the last cycle of each bit period.
module ws2812_bit_timer #(
  parameter int T_BIT = 60,
  parameter int T_H0  = 15,
  parameter int T_H1  = 45
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic bit_in,
  output logic dout,
  output logic bit_end
);

  localparam int                CYC_W    = $clog2(T_BIT);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(T_BIT - 1);

  logic [CYC_W-1:0] cnt_cyc;
  logic             bit_q;
  logic             b;

  assign bit_end = en && (cnt_cyc == CYC_LAST);

  // bit_in is only guaranteed valid for the current address at cycle 0,
  // so later cycles of the bit use the captured copy.
  assign b = (cnt_cyc == '0) ? bit_in : bit_q;

  // Cycle counter, bit capture and registered high/low decision.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_cyc <= '0;
      bit_q   <= 1'b0;
      dout    <= 1'b0;
    end else begin
      cnt_cyc <= (!en || bit_end) ? '0 : cnt_cyc + 1'b1;
      if (en && (cnt_cyc == '0))
        bit_q <= bit_in;
      dout <= en && (32'(cnt_cyc) < (b ? T_H1 : T_H0));
    end
  end

endmodule

// File: rtl/ws2812_frame_drv.sv
// WS2812 frame driver: walks frame/pixel/bit addresses for data_cfg, sends
// each returned bit as an NRZ pulse, then holds the line low for the latch gap.
module ws2812_frame_drv
  import ws2812_pkg::*;
#(
  parameter int T_BIT   = T_BIT_D,
  parameter int T_H0    = T_H0_D,
  parameter int T_H1    = T_H1_D,
  parameter int T_RST   = T_RST_D,
  parameter int N_PIXEL = N_PIXEL_D,
  parameter int N_FRAME = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [3:0] frame_sel,
  input  logic       bit_in,
  output logic [3:0] cnt_in,
  output logic [6:0] cnt_pixel,
  output logic [4:0] cnt_bit,
  output logic       dout,
  output logic       busy,
  output logic       done
);

  localparam int               GAP_W    = $clog2(T_RST);
  localparam logic [6:0]       PIX_LAST = 7'(N_PIXEL - 1);
  localparam logic [4:0]       BIT_LAST = 5'(BITS_PER_PIXEL - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_RST - 1);

  state_t           state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic             send;
  logic             bit_end;
  logic             accept;
  logic             frame_end;
  logic             gap_end;

  assign send      = (state == SEND);
  assign accept    = (state == IDLE) && start;
  assign frame_end = bit_end && (cnt_bit == BIT_LAST) && (cnt_pixel == PIX_LAST);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);

  ws2812_bit_timer #(
    .T_BIT (T_BIT),
    .T_H0  (T_H0),
    .T_H1  (T_H1)
  ) u_bit_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (send),
    .bit_in  (bit_in),
    .dout    (dout),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: start only matters in IDLE, so requests while busy drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = SEND;
      SEND:    if (frame_end) state_nxt = GAP;
      GAP:     if (gap_end)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Address counters, gap timer and the end-of-gap pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_in    <= '0;
      cnt_pixel <= '0;
      cnt_bit   <= '0;
      gap_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done    <= gap_end;
      gap_cnt <= ((state == GAP) && !gap_end) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        cnt_in    <= (32'(frame_sel) >= N_FRAME) ? 4'd0 : frame_sel;
        cnt_pixel <= '0;
        cnt_bit   <= '0;
      end else if (bit_end) begin
        if (cnt_bit == BIT_LAST) begin
          cnt_bit   <= '0;
          cnt_pixel <= (cnt_pixel == PIX_LAST) ? '0 : cnt_pixel + 1'b1;
        end else begin
          cnt_bit <= cnt_bit + 1'b1;
        end
      end
    end
  end

endmodule
